// File: rtl/mem_arb_6502_pkg.sv
// Shared FSM state encoding and constants for the 6502 memory arbiter.
package mem_arb_6502_pkg;

    localparam int unsigned STATE_W    = 3;
    localparam int unsigned RD_LATENCY = 1;

    typedef logic [STATE_W-1:0] arb_state_t;

    localparam arb_state_t IDLE    = 3'd0;
    localparam arb_state_t CPU_RD  = 3'd1;
    localparam arb_state_t CPU_WR  = 3'd2;
    localparam arb_state_t HOST_RD = 3'd3;
    localparam arb_state_t HOST_WR = 3'd4;
    localparam arb_state_t RD_WAIT = 3'd5;

endpackage

// File: rtl/mem_arbiter_6502_phi2_edge_det.sv
// Registers the CPU phase-2 clock and flags its rising and falling edges.
module phi2_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic phi2,
    output logic rise_c,
    output logic fall_c
);

    logic phi2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phi2_q <= 1'b0;
        end else begin
            phi2_q <= phi2;
        end
    end

    assign rise_c = phi2 & ~phi2_q;
    assign fall_c = ~phi2 & phi2_q;

endmodule

// File: rtl/mem_arbiter_6502.sv
// Arbitrates a single-port sync RAM between a 6502 core and a host port.
// Optional MEM_ARB_HOLD_EN adds host_hold/cpu_rdy to stall the CPU.
module mem_arbiter_6502
    import mem_arb_6502_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic              eclk,
    input  logic              ereset_n,
    input  logic              cpu_phi2,
    input  logic [ADDR_W-1:0] cpu_ab,
    input  logic              cpu_rw,
    input  logic [DATA_W-1:0] cpu_do,
    output logic [DATA_W-1:0] cpu_di,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
`ifdef MEM_ARB_HOLD_EN
    input  logic              host_hold,
    output logic              cpu_rdy,
`endif
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic phi2_rise_c;
    logic phi2_fall_c;
    logic cpu_evt_c;

    arb_state_t state_q, state_d;
    logic pend_q, pend_d;
    logic rd_host_q, rd_host_d;
    logic host_done_q, host_done_d;
    logic              lat_rd_q;
    logic [ADDR_W-1:0] lat_addr_q;
    logic [DATA_W-1:0] lat_data_q;

    logic              mem_en_d, mem_we_d, host_ack_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d, cpu_di_d, host_rdata_d;
    logic              dispatch_ok, sel_rd;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    phi2_edge_det u_edge (
        .clk    (eclk),
        .rst_n  (ereset_n),
        .phi2   (cpu_phi2),
        .rise_c (phi2_rise_c),
        .fall_c (phi2_fall_c)
    );

    // Reads start on phi2 rise, writes on phi2 fall (data valid by then).
    assign cpu_evt_c = (phi2_rise_c & cpu_rw) | (phi2_fall_c & ~cpu_rw);

    always_ff @(posedge eclk or negedge ereset_n) begin
        if (!ereset_n) begin
            state_q     <= IDLE;
            pend_q      <= 1'b0;
            rd_host_q   <= 1'b0;
            host_done_q <= 1'b0;
            lat_rd_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_data_q  <= '0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            cpu_di      <= '0;
            host_rdata  <= '0;
            host_ack    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            rd_host_q   <= rd_host_d;
            host_done_q <= host_done_d;
            if (cpu_evt_c) begin
                lat_rd_q   <= cpu_rw;
                lat_addr_q <= cpu_ab;
                lat_data_q <= cpu_do;
            end
            mem_en      <= mem_en_d;
            mem_we      <= mem_we_d;
            mem_addr    <= mem_addr_d;
            mem_wdata   <= mem_wdata_d;
            cpu_di      <= cpu_di_d;
            host_rdata  <= host_rdata_d;
            host_ack    <= host_ack_d;
        end
    end

    // Next state plus next values of all registered outputs.
    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        rd_host_d    = rd_host_q;
        host_done_d  = host_done_q & host_req;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        cpu_di_d     = cpu_di;
        host_rdata_d = host_rdata;
        host_ack_d   = 1'b0;

        dispatch_ok = (state_q == IDLE) || (state_q == CPU_WR) ||
                      (state_q == HOST_WR) || (state_q == RD_WAIT);
        sel_rd   = pend_q ? lat_rd_q   : cpu_rw;
        sel_addr = pend_q ? lat_addr_q : cpu_ab;
        sel_data = pend_q ? lat_data_q : cpu_do;

        if (state_q == RD_WAIT) begin
            if (rd_host_q) begin
                host_rdata_d = mem_rdata;
                host_ack_d   = 1'b1;
            end else begin
                cpu_di_d = mem_rdata;
            end
        end

        if (dispatch_ok && (pend_q || cpu_evt_c)) begin
            // Oldest CPU edge first; a new edge in this cycle stays pending.
            state_d     = sel_rd ? CPU_RD : CPU_WR;
            pend_d      = pend_q & cpu_evt_c;
            rd_host_d   = 1'b0;
            mem_en_d    = 1'b1;
            mem_we_d    = ~sel_rd;
            mem_addr_d  = sel_addr;
            mem_wdata_d = sel_data;
        end else begin
            if (cpu_evt_c) begin
                pend_d = 1'b1;
            end
            if ((state_q == IDLE) && host_req && !host_done_q) begin
                host_done_d = 1'b1;
                mem_en_d    = 1'b1;
                mem_addr_d  = host_addr;
                if (host_we) begin
                    state_d     = HOST_WR;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = host_wdata;
                    host_ack_d  = 1'b1;
                end else begin
                    state_d   = HOST_RD;
                    rd_host_d = 1'b1;
                end
            end else if ((state_q == CPU_RD) || (state_q == HOST_RD)) begin
                state_d = RD_WAIT;
            end else begin
                state_d = IDLE;
            end
        end
    end

`ifdef MEM_ARB_HOLD_EN
    // Stall takes effect only at a phi2 fall so the CPU cycle in progress completes.
    always_ff @(posedge eclk or negedge ereset_n) begin
        if (!ereset_n) begin
            cpu_rdy <= 1'b1;
        end else if (!host_hold) begin
            cpu_rdy <= 1'b1;
        end else if (phi2_fall_c) begin
            cpu_rdy <= 1'b0;
        end
    end
`endif

endmodule
